axis_master_output_fifo: RTL

Parametrised successor to the pipeline-to-AXI-Stream master output stage. It buffers DATA_IN beats in a DEPTH-entry FIFO and drives an AXI4-Stream master with TLAST framing set by a runtime packet length. It raises STOP_PIPELINE early from a fill threshold, so the upstream pipeline can drain without loss, and flags any beat dropped on overflow. It sits at the tail of the detector datapath, in front of the DMA S2MM port.

---
 rtl/axis_master_output_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/axis_master_output_fifo.sv
// AXI4-Stream master output stage: first-word fall-through FIFO with runtime
// packet framing (TLAST), early upstream back-pressure and sticky overflow flag.
`timescale 1ns/1ps

module axis_master_output_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int STOP_MARGIN = 4,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    DATA_IN,
    input  logic                     DATA_IN_VALID,
    input  logic [LEN_WIDTH-1:0]     CFG_PACKET_LEN,
    output logic                     M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic                     M_AXIS_TLAST,
    input  logic                     M_AXIS_TREADY,
    output logic                     STOP_PIPELINE,
    output logic                     OVERFLOW,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [LEN_WIDTH-1:0] bc_q, bc_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 stop_q, stop_d;
    logic                 ovf_q, ovf_d;

    logic                 full;
    logic                 wr_en;
    logic                 rd_en;
    logic                 tvalid;
    logic                 tlast;
    logic [LEN_WIDTH-1:0] len_cfg;
    logic [LEN_WIDTH-1:0] len_eff;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        tvalid  = (count_q != '0);
        rd_en   = tvalid && M_AXIS_TREADY;
        // A read frees a slot in the same cycle, so a full FIFO still accepts.
        wr_en   = DATA_IN_VALID && (!full || rd_en);

        len_cfg = (CFG_PACKET_LEN == '0) ? LEN_WIDTH'(1) : CFG_PACKET_LEN;
        // The first beat of a packet uses the live length so its TLAST is correct immediately.
        len_eff = (bc_q == '0) ? len_cfg : len_q;
        tlast   = tvalid && (bc_q == (len_eff - LEN_WIDTH'(1)));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        bc_d     = bc_q;
        len_d    = len_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            bc_d     = tlast ? '0 : (bc_q + LEN_WIDTH'(1));
        end
        if ((bc_q == '0) && tvalid) begin
            len_d = len_cfg;
        end

        count_d = count_q + CW'(wr_en) - CW'(rd_en);
        stop_d  = ((CW'(DEPTH) - count_d) <= CW'(STOP_MARGIN));
        ovf_d   = ovf_q || (DATA_IN_VALID && !wr_en);
    end

    // Storage carries no reset; TDATA is masked while empty instead.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bc_q     <= '0;
            len_q    <= LEN_WIDTH'(1);
            stop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bc_q     <= bc_d;
            len_q    <= len_d;
            stop_q   <= stop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tvalid ? mem_q[rd_ptr_q] : '0;
    assign M_AXIS_TLAST  = tlast;
    assign STOP_PIPELINE = stop_q;
    assign OVERFLOW      = ovf_q;
    assign FILL_LEVEL    = count_q;

endmodule
